// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier: FSM state encoding and legal operand widths.
// Latency: none, package only.
// Backpressure: none, package only.
package mult_pkg;

    // Two-bit state encoding; code 3 is unused and steers back to idle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH_MIN = 2;
    localparam int MULT_WIDTH_MAX = 16;

endpackage

// File: rtl/seq_mult_ripple_adder.sv
// Half/full adder cells and a WIDTH-bit ripple-carry adder built from them.
// Latency: purely combinational, zero cycles.
// Backpressure: none, always ready.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    // Sum and carry of two bits
    always_comb begin
        s  = a ^ b;
        co = a & b;
    end
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    // Sum and carry of two bits plus carry-in
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end
endmodule

module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    // c[i] is the carry into bit i; bit 0 has no carry-in so it uses a half adder
    logic [WIDTH:1] c;

    half_adder u_ha0 (
        .a  (a[0]),
        .b  (b[0]),
        .s  (sum[0]),
        .co (c[1])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign carry = c[WIDTH];

endmodule

// File: rtl/seq_mult.sv
// Shift-and-add multiplier, one multiplier bit per clock; MULT_SIGNED_EN selects two's complement operands.
// Latency: done pulses WIDTH+1 cycles after start is accepted; one result per WIDTH+2 cycles back-to-back.
// Backpressure: start is only sampled in idle; requests while busy are dropped, not queued.
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    if (WIDTH < MULT_WIDTH_MIN || WIDTH > MULT_WIDTH_MAX) begin : g_width_bad
        $error("seq_mult: WIDTH out of range");
    end

    mult_state_t        state;
    logic [2*WIDTH-1:0] p;       // upper half accumulates, lower half shifts out multiplier bits
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   a_ld;
    logic [WIDTH-1:0]   b_ld;
    logic [2*WIDTH-1:0] result;

    ripple_adder #(.WIDTH(WIDTH)) u_add (
        .a     (p[2*WIDTH-1:WIDTH]),
        .b     (mcand),
        .sum   (sum),
        .carry (carry)
    );

    // Add the multiplicand only when the current multiplier bit is set; keep the carry
    always_comb begin
        acc = p[0] ? {carry, sum} : {1'b0, p[2*WIDTH-1:WIDTH]};
    end

`ifdef MULT_SIGNED_EN
    logic neg;
    logic neg_ld;

    // Work on magnitudes; the most negative value maps to its unsigned magnitude naturally
    always_comb begin
        a_ld   = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
        b_ld   = multiplier[WIDTH-1]   ? -multiplier   : multiplier;
        neg_ld = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
        result = neg ? -p : p;
    end

    // Remember the result sign for the final correction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            neg <= neg_ld;
        end
    end
`else
    // Unsigned operands go straight into the datapath
    always_comb begin
        a_ld   = multiplicand;
        b_ld   = multiplier;
        result = p;
    end
`endif

    // Control FSM with the accumulate/shift datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            p       <= '0;
            mcand   <= '0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand   <= a_ld;
                        p       <= {{WIDTH{1'b0}}, b_ld};
                        count   <= '0;
                        product <= '0;
                        busy    <= 1'b1;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    p     <= {acc, p[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    product <= result;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult at WIDTH=4 and WIDTH=8 with a queue-based result scoreboard.
// Latency: checks done arrives WIDTH+1 cycles after an accepted start.
// Backpressure: drives start only when busy is low, except the deliberate held-start case.
module tb_seq_mult;

    logic        clk;
    logic        rst_n;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  prod4;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;

    int checks = 0;
    int errors = 0;
    int acc4 = 0;
    int dn4 = 0;
    int acc8 = 0;
    int dn8 = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    seq_mult #(.WIDTH(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start4),
        .multiplicand (a4),
        .multiplier   (b4),
        .busy         (busy4),
        .done         (done4),
        .product      (prod4)
    );

    seq_mult #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start8),
        .multiplicand (a8),
        .multiplier   (b8),
        .busy         (busy8),
        .done         (done8),
        .product      (prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [7:0] r;
        r = $signed(a) * $signed(b);
        return r;
`else
        return {4'b0, a} * {4'b0, b};
`endif
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [15:0] r;
        r = $signed(a) * $signed(b);
        return r;
`else
        return {8'b0, a} * {8'b0, b};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard for the 4-bit instance
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            logic [7:0] e;
            dn4++;
            if (q4.size() == 0) begin
                chk("unexpected_done4", {24'b0, prod4}, 32'hFFFF_FFFF);
            end else begin
                e = q4.pop_front();
                chk("product4", {24'b0, prod4}, {24'b0, e});
            end
        end
    end

    // Scoreboard for the 8-bit instance
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            logic [15:0] e;
            dn8++;
            if (q8.size() == 0) begin
                chk("unexpected_done8", {16'b0, prod8}, 32'hFFFF_FFFF);
            end else begin
                e = q8.pop_front();
                chk("product8", {16'b0, prod8}, {16'b0, e});
            end
        end
    end

    task automatic wait_idle4();
        int n = 0;
        while (busy4 !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy4 !== 1'b0) chk("idle4_timeout", {31'b0, busy4}, 32'd0);
    endtask

    task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input bit chk_lat);
        int n;
        wait_idle4();
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        q4.push_back(exp);
        acc4++;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (chk_lat) chk("latency4", n, 32'd5);
        else if (done4 !== 1'b1) chk("done4_timeout", n, 32'd5);
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input bit chk_lat);
        int n = 0;
        while (busy8 !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        q8.push_back(exp);
        acc8++;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (chk_lat) chk("latency8", n, 32'd9);
        else if (done8 !== 1'b1) chk("done8_timeout", n, 32'd9);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;

        // Reset held for three cycles, then idle for ten
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", {31'b0, busy4}, 32'd0);
        chk("rst_done", {31'b0, done4}, 32'd0);
        chk("rst_product", {24'b0, prod4}, 32'd0);
        repeat (10) @(negedge clk);
        chk("idle_busy", {31'b0, busy4}, 32'd0);
        chk("idle_done", {31'b0, done4}, 32'd0);
        chk("idle_product", {24'b0, prod4}, 32'd0);

        // Directed products and latency
`ifdef MULT_SIGNED_EN
        mul4(4'h8, 4'h8, 8'h40, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold4", {24'b0, prod4}, 32'h40);
        mul4(4'hD, 4'h5, 8'hF1, 1'b1);
        mul4(4'h7, 4'hF, 8'hF9, 1'b1);
        mul4(4'h0, 4'hF, 8'h00, 1'b1);
`else
        mul4(4'd13, 4'd11, 8'h8F, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold4", {24'b0, prod4}, 32'h8F);
        mul4(4'd0, 4'd15, 8'h00, 1'b1);
        mul4(4'd15, 4'd15, 8'hE1, 1'b1);
`endif

        // Start held high: second pair only taken once the first completes
        wait_idle4();
        a4 = 4'd3;
        b4 = 4'd5;
        start4 = 1'b1;
        q4.push_back(8'd15);
        acc4++;
        @(negedge clk);
        a4 = 4'd7;
        b4 = 4'd7;
        q4.push_back(8'd49);
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_latency", n, 32'd5);
        chk("b2b_busy_in_done", {31'b0, busy4}, 32'd0);
        acc4++;
        @(negedge clk);
        start4 = 1'b0;
        chk("b2b_busy_second", {31'b0, busy4}, 32'd1);
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_latency", n, 32'd5);

        // Reset during the second calculation cycle aborts the multiply
        wait_idle4();
        a4 = 4'd9;
        b4 = 4'd9;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'b0, busy4}, 32'd0);
        chk("abort_done", {31'b0, done4}, 32'd0);
        chk("abort_product", {24'b0, prod4}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done4}, 32'd0);
        end
        mul4(4'd2, 4'd3, 8'd6, 1'b1);

        // Exhaustive 4-bit sweep
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = 8'(i);
            mul4(ab[7:4], ab[3:0], ref4(ab[7:4], ab[3:0]), 1'b0);
        end

        // Random 8-bit sweep, with corners first
        mul8(8'hFF, 8'hFF, ref8(8'hFF, 8'hFF), 1'b1);
        mul8(8'h80, 8'h80, ref8(8'h80, 8'h80), 1'b0);
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            mul8(ra, rb, ref8(ra, rb), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("done_count4", dn4, acc4);
        chk("done_count8", dn8, acc8);
        chk("queue4_empty", q4.size(), 32'd0);
        chk("queue8_empty", q8.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
